// File: rtl/smbm_sorted_list_pkg.sv
// Shared parameter package for the sorted metric buffer and its consumers.
//   BIT_VEC_SIZE      number of list slots and resource ids
//   BIT_VEC_SIZE_LOG  width of ptr / id
//   VAL_W             metric value width
//   entry_t           {ptr, val} list entry, same layout the selection unit consumes
//   req_op_t          control-plane request opcodes
//   state_t           list maintenance FSM states
package smbm_sorted_list_pkg;

   localparam int BIT_VEC_SIZE     = 64;
   localparam int BIT_VEC_SIZE_LOG = 6;
   localparam int VAL_W            = 16;

   typedef logic [BIT_VEC_SIZE_LOG-1:0] ptr_t;
   typedef logic [BIT_VEC_SIZE_LOG:0]   count_t;
   typedef logic [VAL_W-1:0]            val_t;

   // The all-ones id never names a resource; it marks an empty slot.
   localparam ptr_t EMPTY_PTR = '1;

   typedef struct packed {
      ptr_t ptr;
      val_t val;
   } entry_t;

   localparam entry_t EMPTY_ENTRY = '{ptr: EMPTY_PTR, val: '0};

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_UPSERT = 2'b01,
      OP_DELETE = 2'b10,
      OP_CLEAR  = 2'b11
   } req_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      REMOVE = 2'b01,
      INSERT = 2'b10
   } state_t;

endpackage

// File: rtl/smbm_sorted_list_if.sv
// Request/response and list-export bundle of the sorted metric buffer.
//   master : control-plane writer / list consumer side
//   slave  : the sorted list block
//   req_valid/req_ready/req_op/req_id/req_val  request handshake
//   resp_valid/resp_err                        one-cycle completion
//   metric_list/list_valid/count               exported sorted list
interface smbm_sorted_list_if;
   import smbm_sorted_list_pkg::*;

   logic                          req_valid;
   logic                          req_ready;
   req_op_t                       req_op;
   ptr_t                          req_id;
   val_t                          req_val;
   entry_t [BIT_VEC_SIZE-1:0]     metric_list;
   logic                          list_valid;
   count_t                        count;
   logic                          resp_valid;
   logic                          resp_err;

   modport master (
      output req_valid, req_op, req_id, req_val,
      input  req_ready, metric_list, list_valid, count, resp_valid, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_id, req_val,
      output req_ready, metric_list, list_valid, count, resp_valid, resp_err
   );

endinterface

// File: rtl/priority_encode_log.sv
// Priority encoder: returns the index of the lowest set bit.
//   input_unencoded  request vector
//   output_encoded   index of the lowest set bit (0 when none set)
//   output_valid     at least one bit set
module priority_encode_log #(
   parameter int WIDTH     = 64,
   parameter int LOG_WIDTH = 6
) (
   input  logic [WIDTH-1:0]     input_unencoded,
   output logic [LOG_WIDTH-1:0] output_encoded,
   output logic                 output_valid
);

   // Scanning from the top lets the lowest set bit win by being written last.
   always_comb begin
      output_encoded = '0;
      output_valid   = 1'b0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (input_unencoded[i]) begin
            output_encoded = LOG_WIDTH'(i);
            output_valid   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/smbm_sorted_list.sv
// Sorted metric buffer: one {ptr, val} entry per active resource id, kept
// ascending by val with FIFO order among equal vals.
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of smbm_sorted_list_if (requests in, responses and
//             the sorted list out)
// An upsert or delete first removes any existing entry for the id (REMOVE),
// then an upsert places the new entry at its sorted position (INSERT).
module smbm_sorted_list
   import smbm_sorted_list_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   smbm_sorted_list_if.slave  bus
);

   state_t                    state_q, state_n;
   entry_t [BIT_VEC_SIZE-1:0] list_q, list_n;
   count_t                    count_q, count_n;
   ptr_t                      id_q, id_n;
   val_t                      val_q, val_n;
   req_op_t                   op_q, op_n;
   logic                      resp_valid_q, resp_valid_n;
   logic                      resp_err_q, resp_err_n;

   logic [BIT_VEC_SIZE-1:0]   match_vec;
   logic [BIT_VEC_SIZE-1:0]   gt_vec;
   ptr_t                      rm_idx, gt_idx, ins_pos;
   logic                      rm_found, gt_found;

   // Empty slots carry EMPTY_PTR, and a latched id is never EMPTY_PTR,
   // so only occupied slots can match.
   always_comb begin
      match_vec = '0;
      gt_vec    = '0;
      for (int i = 0; i < BIT_VEC_SIZE; i++) begin
         match_vec[i] = (list_q[i].ptr == id_q);
         gt_vec[i]    = (count_t'(i) < count_q) && (list_q[i].val > val_q);
      end
   end

   priority_encode_log #(.WIDTH(BIT_VEC_SIZE), .LOG_WIDTH(BIT_VEC_SIZE_LOG)) u_match_enc (
      .input_unencoded (match_vec),
      .output_encoded  (rm_idx),
      .output_valid    (rm_found)
   );

   priority_encode_log #(.WIDTH(BIT_VEC_SIZE), .LOG_WIDTH(BIT_VEC_SIZE_LOG)) u_pos_enc (
      .input_unencoded (gt_vec),
      .output_encoded  (gt_idx),
      .output_valid    (gt_found)
   );

   // First strictly greater entry keeps equal vals in arrival order; with no
   // greater entry the new one is appended. count never exceeds 62 here.
   assign ins_pos = gt_found ? gt_idx : count_q[BIT_VEC_SIZE_LOG-1:0];

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_n      = state_q;
      list_n       = list_q;
      count_n      = count_q;
      id_n         = id_q;
      val_n        = val_q;
      op_n         = op_q;
      resp_valid_n = 1'b0;
      resp_err_n   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               unique case (bus.req_op)
                  OP_NOP: begin
                     resp_valid_n = 1'b1;
                  end
                  OP_CLEAR: begin
                     list_n       = {BIT_VEC_SIZE{EMPTY_ENTRY}};
                     count_n      = '0;
                     resp_valid_n = 1'b1;
                  end
                  default: begin
                     if (bus.req_id == EMPTY_PTR) begin
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                     end else begin
                        id_n    = bus.req_id;
                        val_n   = bus.req_val;
                        op_n    = bus.req_op;
                        state_n = REMOVE;
                     end
                  end
               endcase
            end
         end

         REMOVE: begin
            if (rm_found) begin
               for (int i = 0; i < BIT_VEC_SIZE-1; i++) begin
                  if (i >= int'(rm_idx)) list_n[i] = list_q[i+1];
               end
               list_n[BIT_VEC_SIZE-1] = EMPTY_ENTRY;
               count_n = count_q - count_t'(1);
            end
            if (op_q == OP_DELETE) begin
               state_n      = IDLE;
               resp_valid_n = 1'b1;
               resp_err_n   = !rm_found;
            end else begin
               state_n = INSERT;
            end
         end

         INSERT: begin
            for (int i = 1; i < BIT_VEC_SIZE; i++) begin
               if (i > int'(ins_pos)) list_n[i] = list_q[i-1];
            end
            list_n[ins_pos] = '{ptr: id_q, val: val_q};
            count_n         = count_q + count_t'(1);
            state_n         = IDLE;
            resp_valid_n    = 1'b1;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         // NOTE: the list array is reset explicitly; empty slots must read as
         // EMPTY_PTR/0 because consumers see every slot, not just 0..count-1.
         list_q       <= {BIT_VEC_SIZE{EMPTY_ENTRY}};
         count_q      <= '0;
         id_q         <= '0;
         val_q        <= '0;
         op_q         <= OP_NOP;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_n;
         list_q       <= list_n;
         count_q      <= count_n;
         id_q         <= id_n;
         val_q        <= val_n;
         op_q         <= op_n;
         resp_valid_q <= resp_valid_n;
         resp_err_q   <= resp_err_n;
      end
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.list_valid  = (state_q == IDLE);
   assign bus.metric_list = list_q;
   assign bus.count       = count_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_err    = resp_err_q;

endmodule
